// File: rtl/pos_input_sweeper_if.sv
// Handshake and truth-table bus between the input sweeper and its environment.
// The slave side is the sweeper; the master side is the requester plus the function under test.
interface pos_input_sweeper_if;
  logic        start;
  logic        x;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic [4:0]  ones_count;
  logic        pass;

  modport slave (
    input  start, x,
    output a, b, c, d, busy, done, table_out, ones_count, pass
  );

  modport master (
    output start, x,
    input  a, b, c, d, busy, done, table_out, ones_count, pass
  );
endinterface

// File: rtl/pos_input_sweeper.sv
// Steps a..d through all 16 input combinations, captures x into a truth table,
// counts its ones and compares the table against EXPECTED.
module pos_input_sweeper #(
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] EXPECTED      = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  pos_input_sweeper_if.slave bus
);

  localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic [3:0]        idx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [15:0]       table_q;
  logic [4:0]        ones_q;
  logic              pass_q;
  logic              sample_now;
  logic              last_sample;
  logic [15:0]       table_next;

  // The final sample lands on the same edge that enters DONE, so pass is
  // computed from the table including that last bit.
  always_comb begin
    sample_now       = (state == RUN) && (wait_cnt == WAIT_LAST);
    last_sample      = sample_now && (idx == 4'd15);
    table_next       = table_q;
    table_next[idx]  = bus.x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (last_sample) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= 4'd0;
      wait_cnt <= '0;
      table_q  <= 16'd0;
      ones_q   <= 5'd0;
      pass_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx      <= 4'd0;
            wait_cnt <= '0;
            table_q  <= 16'd0;
            ones_q   <= 5'd0;
            pass_q   <= 1'b0;
          end
        end
        RUN: begin
          if (!sample_now) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else begin
            wait_cnt <= '0;
            table_q  <= table_next;
            ones_q   <= ones_q + {4'd0, bus.x};
            if (idx == 4'd15) begin
              pass_q <= (table_next == EXPECTED);
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Inputs are forced to 0000 outside RUN so idx left at 15 never leaks out.
  assign {bus.a, bus.b, bus.c, bus.d} = (state == RUN) ? idx : 4'b0000;
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.table_out  = table_q;
  assign bus.ones_count = ones_q;
  assign bus.pass       = pass_q;

endmodule

// File: tb/tb_pos_input_sweeper.sv
// Self-checking bench for pos_input_sweeper: one instance with SETTLE_CYCLES=1 and one with 3,
// each fed by a programmable truth-table function with an optional 2-cycle delay line on x.
module tb_pos_input_sweeper;

  localparam logic [15:0] GOLD = 16'hAAE0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pos_input_sweeper_if bus1 ();
  pos_input_sweeper_if bus3 ();

  pos_input_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(GOLD)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  pos_input_sweeper #(.SETTLE_CYCLES(3), .EXPECTED(GOLD)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  logic [15:0] func1 = GOLD;
  logic [15:0] func3 = GOLD;
  bit          dly1  = 1'b0;
  bit          dly3  = 1'b0;
  logic        d1_1  = 1'b0;
  logic        d2_1  = 1'b0;
  logic        d1_3  = 1'b0;
  logic        d2_3  = 1'b0;
  logic [3:0]  abcd1;
  logic [3:0]  abcd3;

  assign abcd1   = {bus1.a, bus1.b, bus1.c, bus1.d};
  assign abcd3   = {bus3.a, bus3.b, bus3.c, bus3.d};
  assign bus1.x  = dly1 ? d2_1 : func1[abcd1];
  assign bus3.x  = dly3 ? d2_3 : func3[abcd3];

  always @(posedge clk) begin
    d1_1 <= func1[abcd1];
    d2_1 <= d1_1;
    d1_3 <= func3[abcd3];
    d2_3 <= d1_3;
  end

  // Observation mux: the tasks below talk to whichever instance sel points at.
  bit          sel = 1'b0;
  logic        cur_busy;
  logic        cur_done;
  logic        cur_pass;
  logic [3:0]  cur_abcd;
  logic [15:0] cur_table;
  logic [4:0]  cur_ones;

  assign cur_busy  = sel ? bus3.busy       : bus1.busy;
  assign cur_done  = sel ? bus3.done       : bus1.done;
  assign cur_pass  = sel ? bus3.pass       : bus1.pass;
  assign cur_abcd  = sel ? abcd3           : abcd1;
  assign cur_table = sel ? bus3.table_out  : bus1.table_out;
  assign cur_ones  = sel ? bus3.ones_count : bus1.ones_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          s3;
    logic [15:0] func;
    bit          dl;
    logic [15:0] exp_table;
    logic [4:0]  exp_ones;
    bit          exp_pass;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic setStart(input bit s);
    if (sel) bus3.start = s;
    else     bus1.start = s;
  endtask

  // Capture model: sample k is taken at edge (k+1)*S after the accept edge; with the
  // delay line, x then reflects the inputs shown 2 cycles earlier (0000 before RUN).
  function automatic logic [15:0] modelTable(input logic [15:0] f, input bit dl, input int s);
    logic [15:0] t;
    int j;
    int src;
    for (int k = 0; k < 16; k++) begin
      if (!dl) begin
        src = k;
      end else begin
        j   = (k + 1) * s - 3;
        src = (j < 0) ? 0 : j / s;
      end
      t[k] = f[src];
    end
    return t;
  endfunction

  task automatic applyStimulus(input bit s3, input logic [15:0] f, input bit dl,
                               output int lat, output int step_err);
    int s;
    s   = s3 ? 3 : 1;
    sel = s3;
    if (s3) begin func3 = f; dly3 = dl; end
    else    begin func1 = f; dly1 = dl; end
    repeat (4) @(negedge clk);
    setStart(1'b1);
    @(posedge clk);
    #1;
    setStart(1'b0);
    lat      = 1;
    step_err = 0;
    while (!cur_done && lat < 16 * s + 20) begin
      if (cur_abcd !== 4'((lat - 1) / s) || cur_busy !== 1'b1) step_err++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic waitAbcd(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (cur_busy && cur_abcd == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (cur_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int step_err;
    int cnt;
    int s;
    bit ok;
    logic [15:0] f;
    logic [15:0] et;
    bit s3;
    bit dl;

    vecs[0] = '{1'b0, GOLD,     1'b0, GOLD,     5'd7,  1'b1};
    vecs[1] = '{1'b0, 16'hAAE1, 1'b0, 16'hAAE1, 5'd8,  1'b0};
    vecs[2] = '{1'b1, GOLD,     1'b1, GOLD,     5'd7,  1'b1};
    vecs[3] = '{1'b0, GOLD,     1'b1, 16'hAB80, 5'd6,  1'b0};
    vecs[4] = '{1'b1, 16'hFFFF, 1'b0, 16'hFFFF, 5'd16, 1'b0};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 5'd0,  1'b0};
    vecs[6] = '{1'b1, 16'hAAE1, 1'b1, 16'hAAE1, 5'd8,  1'b0};

    // Reset held with start asserted: nothing may move.
    bus1.start = 1'b1;
    bus3.start = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",  {31'd0, bus1.busy | bus3.busy}, 32'd0);
    checkOutput("rst_done",  {31'd0, bus1.done | bus3.done}, 32'd0);
    checkOutput("rst_abcd",  {28'd0, abcd1 | abcd3}, 32'd0);
    checkOutput("rst_table", {16'd0, bus1.table_out | bus3.table_out}, 32'd0);
    checkOutput("rst_ones",  {27'd0, bus1.ones_count | bus3.ones_count}, 32'd0);
    checkOutput("rst_pass",  {31'd0, bus1.pass | bus3.pass}, 32'd0);
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus1.busy || bus3.busy || bus1.done || bus3.done) cnt++;
    end
    checkOutput("idle_no_start", cnt, 0);

    for (int v = 0; v < 7; v++) begin
      s = vecs[v].s3 ? 3 : 1;
      applyStimulus(vecs[v].s3, vecs[v].func, vecs[v].dl, lat, step_err);
      $display("[TB] vector %0d settle=%0d delay=%0d", v, s, vecs[v].dl);
      checkOutput("vec_latency", lat, 16 * s + 1);
      checkOutput("vec_steps",   step_err, 0);
      checkOutput("vec_table",   {16'd0, cur_table}, {16'd0, vecs[v].exp_table});
      checkOutput("vec_ones",    {27'd0, cur_ones},  {27'd0, vecs[v].exp_ones});
      checkOutput("vec_pass",    {31'd0, cur_pass},  {31'd0, vecs[v].exp_pass});
      @(posedge clk);
      #1;
      checkOutput("vec_done_pulse", {27'd0, cur_done, cur_abcd}, 32'd0);
      checkOutput("vec_hold_table", {16'd0, cur_table}, {16'd0, vecs[v].exp_table});
    end

    for (int r = 0; r < 10; r++) begin
      s3 = 1'($urandom_range(0, 1));
      dl = 1'($urandom_range(0, 1));
      f  = 16'($urandom);
      if (r == 0) f = GOLD;
      s  = s3 ? 3 : 1;
      et = modelTable(f, dl, s);
      applyStimulus(s3, f, dl, lat, step_err);
      checkOutput("rnd_latency", lat, 16 * s + 1);
      checkOutput("rnd_steps",   step_err, 0);
      checkOutput("rnd_table",   {16'd0, cur_table}, {16'd0, et});
      checkOutput("rnd_ones",    {27'd0, cur_ones},  $countones(et));
      checkOutput("rnd_pass",    {31'd0, cur_pass},  {31'd0, (et == GOLD)});
    end

    // Start pulsed mid-sweep must be ignored.
    sel = 1'b0; func1 = GOLD; dly1 = 1'b0;
    repeat (3) @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    waitAbcd(4'd7, ok);
    checkOutput("abuse_reach_idx7", {31'd0, ok}, 32'd1);
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (cur_done) cnt++;
    end
    checkOutput("abuse_single_done", cnt, 1);
    checkOutput("abuse_table", {16'd0, cur_table}, {16'd0, GOLD});

    // Start held high: exactly one IDLE cycle between DONE and the next RUN.
    @(negedge clk);
    bus1.start = 1'b1;
    waitDone(ok);
    checkOutput("held_first_done", {31'd0, ok}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (cur_busy) break;
      cnt++;
    end
    checkOutput("held_idle_gap", cnt, 1);
    @(negedge clk);
    bus1.start = 1'b0;
    waitDone(ok);
    checkOutput("held_second_done", {31'd0, ok}, 32'd1);
    checkOutput("held_second_table", {16'd0, cur_table}, {16'd0, GOLD});

    // Asynchronous reset at idx 9, then a clean sweep.
    repeat (3) @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    waitAbcd(4'd9, ok);
    checkOutput("midrst_reach_idx9", {31'd0, ok}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy",  {31'd0, cur_busy}, 32'd0);
    checkOutput("midrst_abcd",  {28'd0, cur_abcd}, 32'd0);
    checkOutput("midrst_table", {16'd0, cur_table}, 32'd0);
    checkOutput("midrst_ones",  {27'd0, cur_ones}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (cur_busy) cnt++;
    end
    checkOutput("midrst_no_restart", cnt, 0);
    applyStimulus(1'b0, GOLD, 1'b0, lat, step_err);
    checkOutput("midrst_latency", lat, 17);
    checkOutput("midrst_steps",   step_err, 0);
    checkOutput("midrst_table2",  {16'd0, cur_table}, {16'd0, GOLD});
    checkOutput("midrst_pass",    {31'd0, cur_pass}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pos_input_sweeper.md
# pos_input_sweeper

Self-checking stimulus/capture stage for the 4-input sum/product-of-terms lab functions. On a start request it drives inputs a,b,c,d through all 16 combinations, samples the function output x for each one, and assembles the 16-bit truth table and its count of ones. The result is compared against an expected table, giving a single pass/fail. It sits directly upstream of the combinational function (drives a..d) and downstream of it (consumes x).

## Interface
- SETTLE_CYCLES, 1: cycles each input combination is held before x is sampled; legal range ≥1.
- EXPECTED, 16'h0000: reference truth table; bit i = expected x for input index i.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- start  input  1  sweep request, sampled on clk; only acted on in IDLE.
- x  input  1  function output under test (combinational from a..d).
- a, b, c, d  output  1 each  function inputs; index = {a,b,c,d}, a is MSB.
- busy  output  1  high while sweeping (RUN).
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  16  captured truth table; bit i = x sampled at index i.
- ones_count  output  5  number of 1 bits captured (0..16).
- pass  output  1  table_out == EXPECTED; valid from done, held until next start.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: a..d = 0000, busy=0. start=1 at an edge → RUN; on that same edge idx=0, wait=0, table_out=0, ones_count=0, pass=0.
- RUN: a..d = idx (registered, so changes only on clk edges); busy=1. Each edge: if wait < SETTLE_CYCLES-1, wait++. Else sample x: table_out[idx]=x, ones_count += x, wait=0; if idx==15 → DONE, else idx++.
- DONE: done=1 for exactly this cycle; pass = (table_out == EXPECTED), registered on entry to DONE. Next edge → IDLE, a..d return to 0000.
- table_out, ones_count, pass hold their values in IDLE until the next accepted start.
- start in RUN or DONE is ignored (not queued). start held continuously in IDLE launches a new sweep immediately after each DONE.
- idx is 4 bits and never wraps inside a sweep; the sweep ends at idx 15.
- ones_count saturation is not needed; it cannot exceed 16.

## Timing
- Reset (rst_n=0, any time including mid-RUN): state=IDLE, a..d=0000, busy=0, done=0, table_out=0, ones_count=0, pass=0, idx=0, wait=0. Takes effect immediately, without waiting for a clk edge.
- Start accepted at edge E0. RUN lasts exactly 16×SETTLE_CYCLES cycles, and samples occur on edges E0+k×SETTLE_CYCLES, k=1..16.
- done is high for the cycle after the 16th sample. Start-to-done latency = 16×SETTLE_CYCLES+1 edges.
- x is sampled at the last edge of each hold window. x must settle within SETTLE_CYCLES clock periods of a..d changing.
- pass and the final table_out/ones_count are valid in the same cycle as done.
- Back-to-back: with start held high, the next RUN begins 2 edges after the final sample (DONE, then the IDLE accept edge).

## Test plan
- Reset: hold rst_n=0, pulse start → all outputs 0, state IDLE; deassert rst_n and confirm no sweep starts without start.
- Golden sweep (SETTLE_CYCLES=1, EXPECTED=16'hAAE0): connect a function with x=0 at indices 0,1,2,3,4,8,10,12,14 and 1 elsewhere, pulse start → a..d step 0000..1111 one per cycle, done 17 edges after start, table_out=16'hAAE0, ones_count=7, pass=1.
- Mismatch: same setup but force x=1 at index 0 → table_out=16'hAAE1, ones_count=8, pass=0.
- Settle: SETTLE_CYCLES=3, x driven through a 2-cycle delay line → each index held 3 cycles, done at edge 49, capture correct, pass=1; with SETTLE_CYCLES=1 the same delay gives pass=0.
- Start abuse: start pulsed during RUN at idx 7 → ignored, single done. Start held high → consecutive sweeps with exactly one IDLE cycle between DONE and the next RUN.
- Reset mid-operation: assert rst_n=0 at idx 9 → immediate IDLE, table_out=0. A fresh start after release completes a full 16-index sweep.
